// File: rtl/i2c_config_sequencer.sv
// rtl/i2c_config_sequencer.sv - walks a register table through i2c_write_reg with retries, settle gap and watchdog
module i2c_config_sequencer #(
  parameter logic [6:0] DEV_ADDRESS  = 7'h52,
  parameter int         NUM_WRITES   = 8,
  parameter int         IDX_W        = 4,
  parameter int         MAX_RETRIES  = 3,
  parameter int         GAP_CYCLES   = 16,
  parameter int         WAIT_TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             failure,
  output logic [IDX_W-1:0] fail_index,
  output logic [IDX_W-1:0] table_index,
  input  logic [7:0]       table_reg_address,
  input  logic [7:0]       table_data,
  output logic [6:0]       wr_dev_address,
  output logic [7:0]       wr_reg_address,
  output logic [7:0]       wr_data,
  output logic             wr_start,
  output logic             wr_reset,
  input  logic             wr_done,
  input  logic             wr_failure
);

  localparam int TMAX = (GAP_CYCLES > WAIT_TIMEOUT) ? GAP_CYCLES : WAIT_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_WRITES - 1);
  localparam logic [RW-1:0]    RETRY_LIMIT = RW'(MAX_RETRIES);
  localparam logic [TW-1:0]    WAIT_LAST   = TW'(WAIT_TIMEOUT - 1);
  localparam logic [TW-1:0]    GAP_LAST    = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_FAIL} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [RW-1:0]    retries, retries_n;
  logic [TW-1:0]    timer, timer_n;
  logic             busy_n, done_n, failure_n, wr_start_n, wr_reset_n;
  logic [IDX_W-1:0] fail_index_n;
  logic [6:0]       wr_dev_address_n;
  logic [7:0]       wr_reg_address_n, wr_data_n;
  logic             attempt_ok, attempt_bad;

  assign table_index = idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      idx            <= '0;
      retries        <= '0;
      timer          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      failure        <= 1'b0;
      fail_index     <= '0;
      wr_dev_address <= '0;
      wr_reg_address <= '0;
      wr_data        <= '0;
      wr_start       <= 1'b0;
      wr_reset       <= 1'b0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      retries        <= retries_n;
      timer          <= timer_n;
      busy           <= busy_n;
      done           <= done_n;
      failure        <= failure_n;
      fail_index     <= fail_index_n;
      wr_dev_address <= wr_dev_address_n;
      wr_reg_address <= wr_reg_address_n;
      wr_data        <= wr_data_n;
      wr_start       <= wr_start_n;
      wr_reset       <= wr_reset_n;
    end
  end

  always_comb begin
    state_n          = state;
    idx_n            = idx;
    retries_n        = retries;
    timer_n          = timer;
    busy_n           = busy;
    done_n           = 1'b0;
    failure_n        = failure;
    fail_index_n     = fail_index;
    wr_dev_address_n = wr_dev_address;
    wr_reg_address_n = wr_reg_address;
    wr_data_n        = wr_data;
    wr_start_n       = 1'b0;
    wr_reset_n       = 1'b0;
    attempt_ok       = 1'b0;
    attempt_bad      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          failure_n = 1'b0;
          idx_n     = '0;
          retries_n = '0;
          busy_n    = 1'b1;
          state_n   = S_FETCH;
        end
      end
      S_FETCH: begin
        // wr_start is registered, so it is raised here to be high during ISSUE
        wr_reg_address_n = table_reg_address;
        wr_data_n        = table_data;
        wr_dev_address_n = DEV_ADDRESS;
        wr_start_n       = 1'b1;
        state_n          = S_ISSUE;
      end
      S_ISSUE: begin
        timer_n = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        timer_n = timer + 1'b1;
        if (wr_failure) begin
          attempt_bad = 1'b1;
        end else if (timer == WAIT_LAST) begin
          attempt_bad = 1'b1;
          wr_reset_n  = 1'b1;
        end else if (wr_done) begin
          attempt_ok = 1'b1;
        end

        if (attempt_ok) begin
          if (idx == LAST_IDX) begin
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            idx_n     = idx + 1'b1;
            retries_n = '0;
            timer_n   = '0;
            state_n   = S_GAP;
          end
        end else if (attempt_bad) begin
          if (retries < RETRY_LIMIT) begin
            retries_n = retries + 1'b1;
            timer_n   = '0;
            state_n   = S_GAP;
          end else begin
            fail_index_n = idx;
            state_n      = S_FAIL;
          end
        end
      end
      S_GAP: begin
        if (timer == GAP_LAST) begin
          state_n = S_FETCH;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      S_FAIL: begin
        failure_n = 1'b1;
        busy_n    = 1'b0;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb/tb_i2c_config_sequencer.sv - directed table-driven bench for i2c_config_sequencer
module tb_i2c_config_sequencer;

  localparam int GAP = 4;
  localparam int LAT = 50;

  logic       clk = 1'b0;
  logic       reset, start, wd_start;
  logic       busy, done, failure, wr_start, wr_reset, wr_done, wr_failure;
  logic [3:0] fail_index, table_index;
  logic [7:0] table_reg_address, table_data, wr_reg_address, wr_data;
  logic [6:0] wr_dev_address;

  logic       wd_busy, wd_done, wd_failure, wd_wr_start, wd_wr_reset;
  logic [3:0] wd_fail_index, wd_table_index;
  logic [7:0] wd_wr_reg_address, wd_wr_data;
  logic [6:0] wd_wr_dev_address;

  always #5 clk = ~clk;

  function automatic logic [7:0] tdata(input logic [3:0] i);
    return 8'h5A + {4'h0, i} * 8'd3;
  endfunction

  assign table_reg_address = 8'h10 + {4'h0, table_index};
  assign table_data        = tdata(table_index);

  i2c_config_sequencer #(.NUM_WRITES(3), .IDX_W(4), .MAX_RETRIES(3), .GAP_CYCLES(GAP), .WAIT_TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .failure(failure),
    .fail_index(fail_index), .table_index(table_index), .table_reg_address(table_reg_address),
    .table_data(table_data), .wr_dev_address(wr_dev_address), .wr_reg_address(wr_reg_address),
    .wr_data(wr_data), .wr_start(wr_start), .wr_reset(wr_reset), .wr_done(wr_done),
    .wr_failure(wr_failure)
  );

  // Second instance with a silent write block to exercise the watchdog
  i2c_config_sequencer #(.NUM_WRITES(3), .IDX_W(4), .MAX_RETRIES(1), .GAP_CYCLES(GAP), .WAIT_TIMEOUT(100)) dut_wd (
    .clk(clk), .reset(reset), .start(wd_start), .busy(wd_busy), .done(wd_done), .failure(wd_failure),
    .fail_index(wd_fail_index), .table_index(wd_table_index), .table_reg_address(8'h33),
    .table_data(8'h44), .wr_dev_address(wd_wr_dev_address), .wr_reg_address(wd_wr_reg_address),
    .wr_data(wd_wr_data), .wr_start(wd_wr_start), .wr_reset(wd_wr_reset), .wr_done(1'b0),
    .wr_failure(1'b0)
  );

  typedef struct packed {
    logic [6:0] dev;
    logic [7:0] ra;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    int          fail_entry;
    int          fail_count;
    bit          both;
    bit          start_in_wait;
    int          exp_n;
    logic [31:0] exp_seq;
    bit          exp_done;
    bit          exp_failure;
    logic [3:0]  exp_fidx;
  } vec_t;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  wr_t starts[$];
  int  done_cnt, gap_bad, busy_bad, last_resp;
  bit  prev_done;
  int  fail_entry, fail_count, fail_used;
  bit  both;
  int  cd;
  bit  pend_fail, pend_both;
  int  entry;
  int  wd_starts, wd_resets, wd_last_start, wd_first_gap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor then write-block model, evaluated once per negedge
  initial begin
    wr_done = 1'b0; wr_failure = 1'b0; cd = 0; last_resp = -1; prev_done = 1'b0;
    done_cnt = 0; gap_bad = 0; busy_bad = 0; fail_entry = 0; fail_count = 0; fail_used = 0;
    both = 1'b0; pend_fail = 1'b0; pend_both = 1'b0;
    wd_starts = 0; wd_resets = 0; wd_last_start = 0; wd_first_gap = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (wr_start) begin
        starts.push_back('{dev: wr_dev_address, ra: wr_reg_address, d: wr_data});
        if (last_resp >= 0 && cyc - last_resp != GAP + 2) gap_bad++;
      end
      if (prev_done && busy) busy_bad++;
      prev_done = done;
      if (done) done_cnt++;
      if (wd_wr_start) begin
        wd_starts++;
        wd_last_start = cyc;
      end
      if (wd_wr_reset) begin
        wd_resets++;
        if (wd_resets == 1) wd_first_gap = cyc - wd_last_start;
      end

      wr_done = 1'b0;
      wr_failure = 1'b0;
      if (reset) begin
        cd = 0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          if (pend_fail) begin
            wr_failure = 1'b1;
            wr_done = pend_both;
          end else begin
            wr_done = 1'b1;
          end
          last_resp = cyc;
        end
      end
      if (wr_start && !reset) begin
        cd = LAT;
        entry = int'(wr_reg_address) - 16;
        pend_fail = (entry == fail_entry) && (fail_used < fail_count);
        if (pend_fail) fail_used++;
        pend_both = both;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    last_resp = -1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("failure_cleared", failure, 0);
    check("first_table_index", table_index, 0);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(name, busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_failure"}, failure, 0);
    check({tag, "_wr_start"}, wr_start, 0);
    check({tag, "_wr_reset"}, wr_reset, 0);
    check({tag, "_table_index"}, table_index, 0);
    check({tag, "_fail_index"}, fail_index, 0);
    check({tag, "_wr_regs"}, {wr_dev_address, wr_reg_address, wr_data}, 0);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{fail_entry: 0, fail_count: 0,  both: 0, start_in_wait: 0, exp_n: 3,
                exp_seq: 32'h0000_0210, exp_done: 1, exp_failure: 0, exp_fidx: 4'd0};
    vecs[1] = '{fail_entry: 1, fail_count: 2,  both: 0, start_in_wait: 0, exp_n: 5,
                exp_seq: 32'h0002_1110, exp_done: 1, exp_failure: 0, exp_fidx: 4'd0};
    vecs[2] = '{fail_entry: 2, fail_count: 99, both: 0, start_in_wait: 0, exp_n: 6,
                exp_seq: 32'h0022_2210, exp_done: 0, exp_failure: 1, exp_fidx: 4'd2};
    vecs[3] = '{fail_entry: 0, fail_count: 1,  both: 1, start_in_wait: 1, exp_n: 4,
                exp_seq: 32'h0000_2100, exp_done: 1, exp_failure: 0, exp_fidx: 4'd0};

    reset = 1'b1; start = 1'b0; wd_start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    check("reset_wd_busy", wd_busy, 0);
    reset = 1'b0;

    foreach (vecs[v]) begin
      fail_entry = vecs[v].fail_entry;
      fail_count = vecs[v].fail_count;
      both = vecs[v].both;
      fail_used = 0;
      starts.delete();
      done_cnt = 0; gap_bad = 0; busy_bad = 0;
      pulse_start();
      if (vecs[v].start_in_wait) begin
        int k = 0;
        while (starts.size() < 1 && k < 100) begin
          @(negedge clk);
          k++;
        end
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_idle($sformatf("v%0d_idle", v));
      check($sformatf("v%0d_num_starts", v), starts.size(), vecs[v].exp_n);
      for (int i = 0; i < vecs[v].exp_n && i < starts.size(); i++) begin
        logic [3:0] e;
        e = vecs[v].exp_seq[i*4 +: 4];
        check($sformatf("v%0d_s%0d_reg", v, i), starts[i].ra, 8'h10 + {4'h0, e});
        check($sformatf("v%0d_s%0d_data", v, i), starts[i].d, tdata(e));
        check($sformatf("v%0d_s%0d_dev", v, i), starts[i].dev, 7'h52);
      end
      check($sformatf("v%0d_done_cnt", v), done_cnt, vecs[v].exp_done ? 1 : 0);
      check($sformatf("v%0d_failure", v), failure, vecs[v].exp_failure);
      if (vecs[v].exp_failure) check($sformatf("v%0d_fail_index", v), fail_index, vecs[v].exp_fidx);
      check($sformatf("v%0d_gap", v), gap_bad, 0);
      check($sformatf("v%0d_busy_after_done", v), busy_bad, 0);
    end

    begin
      int k = 0;
      @(negedge clk);
      wd_start = 1'b1;
      @(negedge clk);
      wd_start = 1'b0;
      check("wd_busy", wd_busy, 1);
      while (wd_busy && k < 3000) begin
        @(negedge clk);
        k++;
      end
      check("wd_idle", wd_busy, 0);
      check("wd_starts", wd_starts, 2);
      check("wd_resets", wd_resets, 2);
      check("wd_reset_timing", wd_first_gap, 101);
      check("wd_failure", wd_failure, 1);
      check("wd_fail_index", wd_fail_index, 0);
    end

    begin
      int k = 0;
      fail_count = 0; fail_used = 0; both = 1'b0;
      starts.delete();
      done_cnt = 0;
      pulse_start();
      while (starts.size() < 2 && k < 1000) begin
        @(negedge clk);
        k++;
      end
      check("mid_second_start", starts.size(), 2);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("mid");
      reset = 1'b0;
      repeat (60) @(negedge clk);
      check("mid_no_done", done_cnt, 0);
      check("mid_no_failure", failure, 0);
      check("mid_stays_idle", busy, 0);
      starts.delete();
      gap_bad = 0;
      pulse_start();
      wait_idle("restart_idle");
      check("restart_starts", starts.size(), 3);
      if (starts.size() > 0) check("restart_first_reg", starts[0].ra, 8'h10);
      check("restart_done", done_cnt, 1);
      check("restart_gap", gap_bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
